// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues sequential reads to a 1-cycle-latency instruction memory
// and buffers responses in a 2-entry FIFO toward the decoder, with redirect and start/stop.
module inst_fetch #(
  parameter int unsigned ISA_WIDTH  = 16,
  parameter int unsigned PC_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 jump_valid,
  input  logic [PC_WIDTH-1:0]  jump_target,
  output logic                 imem_rd_en,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic [ISA_WIDTH-1:0] imem_rdata,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [ISA_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]  inst_pc
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [PC_WIDTH-1:0]  req_pc_q;
  logic                 inflight_q;
  logic [1:0]           count_q, count_d;
  logic [ISA_WIDTH-1:0] inst0_q, inst1_q, inst0_d, inst1_d;
  logic [PC_WIDTH-1:0]  ipc0_q, ipc1_q, ipc0_d, ipc1_d;
  logic                 push, pop;
  logic [2:0]           occ;

  assign inst_valid = (count_q != 2'd0);
  assign inst       = inst0_q;
  assign inst_pc    = ipc0_q;
  assign imem_addr  = pc_q;

  assign pop  = inst_valid & inst_ready;
  assign push = inflight_q & ~jump_valid;

  // Credit counts the slot freed by this cycle's pop so the stream sustains 1 inst/cycle.
  assign occ        = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign imem_rd_en = (state_q == StRun) & ~jump_valid & (occ < 3'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start && !stop) state_d = StRun;
      StRun:  if (stop) state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (jump_valid) begin
      pc_d = jump_target;
    end else if (imem_rd_en) begin
      pc_d = pc_q + PC_WIDTH'(1);
    end
  end

  // Two-entry shift buffer: entry 0 is always the head.
  always_comb begin
    count_d = count_q;
    inst0_d = inst0_q;
    inst1_d = inst1_q;
    ipc0_d  = ipc0_q;
    ipc1_d  = ipc1_q;
    if (jump_valid) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            inst0_d = imem_rdata;
            ipc0_d  = req_pc_q;
          end else begin
            inst1_d = imem_rdata;
            ipc1_d  = req_pc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          inst0_d = inst1_q;
          ipc0_d  = ipc1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            inst0_d = imem_rdata;
            ipc0_d  = req_pc_q;
          end else begin
            inst0_d = inst1_q;
            ipc0_d  = ipc1_q;
            inst1_d = imem_rdata;
            ipc1_d  = req_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      inst0_q    <= '0;
      inst1_q    <= '0;
      ipc0_q     <= '0;
      ipc1_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= pc_q;
      inflight_q <= imem_rd_en;
      count_q    <= count_d;
      inst0_q    <= inst0_d;
      inst1_q    <= inst1_d;
      ipc0_q     <= ipc0_d;
      ipc1_q     <= ipc1_d;
    end
  end

endmodule
